// File: rtl/csr_ext_router.sv
// rtl/csr_ext_router.sv - CSR dispatch stage routing requests to extension CSR blocks
module csr_ext_router #(
   parameter int                    NUM_EXT    = 4,
   parameter int                    NUM_LANES  = 4,
   parameter int                    XLEN       = 32,
   parameter int                    NW_WIDTH   = 4,
   parameter int                    TAG_WIDTH  = 48,
   parameter logic [NUM_EXT*12-1:0] ADDR_BASE  = {12'h7D8, 12'h7D0, 12'h7C8, 12'h7C0},
   parameter logic [NUM_EXT*12-1:0] ADDR_END   = {12'h7E0, 12'h7D8, 12'h7D0, 12'h7C8},
   parameter logic [NUM_EXT-1:0]    DRAIN_MASK = '0,
   parameter int                    TIMEOUT    = 64,
   parameter int                    RSP_DEPTH  = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_write,
   input  logic [11:0]                       req_addr,
   input  logic [NW_WIDTH-1:0]               req_wid,
   input  logic [NUM_LANES-1:0]              req_tmask,
   input  logic [NUM_LANES*XLEN-1:0]         req_data,
   input  logic [TAG_WIDTH-1:0]              req_tag,
   output logic [NW_WIDTH-1:0]               drain_wid,
   input  logic                              alm_empty,
   output logic [NUM_EXT-1:0]                ext_req_valid,
   input  logic [NUM_EXT-1:0]                ext_req_ready,
   output logic                              ext_req_write,
   output logic [11:0]                       ext_req_addr,
   output logic [NW_WIDTH-1:0]               ext_req_wid,
   output logic [NUM_LANES-1:0]              ext_req_tmask,
   output logic [NUM_LANES*XLEN-1:0]         ext_req_data,
   input  logic [NUM_EXT-1:0]                ext_rsp_valid,
   input  logic [NUM_EXT*NUM_LANES*XLEN-1:0] ext_rsp_data,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [TAG_WIDTH-1:0]              rsp_tag,
   output logic [NW_WIDTH-1:0]               rsp_wid,
   output logic [NUM_LANES-1:0]              rsp_tmask,
   output logic [NUM_LANES*XLEN-1:0]         rsp_data,
   output logic                              rsp_err
);
   localparam int DW     = NUM_LANES * XLEN;
   localparam int TGT_W  = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int FCNT_W = $clog2(RSP_DEPTH + 1);
   localparam int EW     = 1 + TAG_WIDTH + NW_WIDTH + NUM_LANES + DW;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT_RSP, S_COMPLETE} state_t;

   state_t                r_state, w_next;
   logic                  r_write;
   logic [11:0]           r_addr;
   logic [NW_WIDTH-1:0]   r_wid;
   logic [NUM_LANES-1:0]  r_tmask;
   logic [DW-1:0]         r_data;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [TGT_W-1:0]      r_tgt;
   logic [CNT_W-1:0]      r_cnt;
   logic [EW-1:0]         r_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
   logic [FCNT_W-1:0]     r_count;

   logic                  w_hit, w_accept, w_push, w_push_err, w_pop;
   logic [TGT_W-1:0]      w_tgt;
   logic [DW-1:0]         w_push_data, w_rsp_slice;
   logic [EW-1:0]         w_head;

   // Address decode: scan downward so the lowest matching window wins
   always_comb begin
      w_hit = 1'b0;
      w_tgt = '0;
      for (int i = NUM_EXT - 1; i >= 0; i--) begin
         if (req_addr >= ADDR_BASE[i*12 +: 12] && req_addr < ADDR_END[i*12 +: 12]) begin
            w_hit = 1'b1;
            w_tgt = TGT_W'(i);
         end
      end
   end

   // Select the owning target's read data lane bundle
   always_comb begin
      w_rsp_slice = '0;
      for (int i = 0; i < NUM_EXT; i++) begin
         if (r_tgt == TGT_W'(i)) w_rsp_slice = ext_rsp_data[i*DW +: DW];
      end
   end

   // A free FIFO slot is reserved at accept, so later pushes never stall
   assign req_ready = !reset && (r_state == S_IDLE) && (r_count < FCNT_W'(RSP_DEPTH));
   assign w_accept  = req_valid && req_ready;
   assign w_pop     = rsp_valid && rsp_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and completion push decisions
   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_push_err  = 1'b0;
      w_push_data = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_hit)                 w_next = S_COMPLETE;
               else if (DRAIN_MASK[w_tgt]) w_next = S_DRAIN;
               else                        w_next = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (alm_empty) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (ext_req_ready[r_tgt]) begin
               if (r_write) begin
                  w_push = 1'b1;
                  w_next = S_IDLE;
               end else begin
                  w_next = S_WAIT_RSP;
               end
            end
         end
         S_WAIT_RSP: begin
            if (ext_rsp_valid[r_tgt]) begin
               w_push      = 1'b1;
               w_push_data = w_rsp_slice;
               w_next      = S_IDLE;
            end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
               w_push     = 1'b1;
               w_push_err = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_COMPLETE: begin
            w_push     = 1'b1;
            w_push_err = 1'b1;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Latch the accepted request; these registers also drive the broadcast fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wid   <= '0;
         r_tmask <= '0;
         r_data  <= '0;
         r_tag   <= '0;
         r_tgt   <= '0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wid   <= req_wid;
         r_tmask <= req_tmask;
         r_data  <= req_data;
         r_tag   <= req_tag;
         r_tgt   <= w_tgt;
      end
   end

   // Read timeout counter: runs only while waiting, saturates at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_cnt <= '0;
      else if (r_state != S_WAIT_RSP)   r_cnt <= '0;
      else if (r_cnt != {CNT_W{1'b1}})  r_cnt <= r_cnt + CNT_W'(1);
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + FCNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - FCNT_W'(1);
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_push_err, r_tag, r_wid, r_tmask, w_push_data};
   end

   assign rsp_valid = (r_count != '0);
   assign w_head    = rsp_valid ? r_mem[r_rd_ptr] : '0;
   assign {rsp_err, rsp_tag, rsp_wid, rsp_tmask, rsp_data} = w_head;

   assign ext_req_valid = (r_state == S_ISSUE) ? (NUM_EXT'(1) << r_tgt) : '0;
   assign ext_req_write = r_write;
   assign ext_req_addr  = r_addr;
   assign ext_req_wid   = r_wid;
   assign ext_req_tmask = r_tmask;
   assign ext_req_data  = r_data;
   assign drain_wid     = r_wid;
endmodule

// File: tb/tb_csr_ext_router.sv
// tb/tb_csr_ext_router.sv - self-checking bench for csr_ext_router
module tb_csr_ext_router;
   localparam int NE = 4, NL = 4, XL = 32, NW = 4, TW = 48, DW = 128, TO = 8, DEPTH = 2;
   localparam logic [47:0] BASE = {12'h7D8, 12'h7D0, 12'h7C6, 12'h7C0};
   localparam logic [47:0] ENDA = {12'h7E0, 12'h7D8, 12'h7D0, 12'h7C8};

   int base_a [NE] = '{'h7C0, 'h7C6, 'h7D0, 'h7D8};
   int end_a  [NE] = '{'h7C8, 'h7D0, 'h7D8, 'h7E0};

   logic            clk, reset;
   logic            req_valid, req_ready, req_write;
   logic [11:0]     req_addr;
   logic [NW-1:0]   req_wid;
   logic [NL-1:0]   req_tmask;
   logic [DW-1:0]   req_data;
   logic [TW-1:0]   req_tag;
   logic [NW-1:0]   drain_wid;
   logic            alm_empty;
   logic [NE-1:0]   ext_req_valid, ext_req_ready;
   logic            ext_req_write;
   logic [11:0]     ext_req_addr;
   logic [NW-1:0]   ext_req_wid;
   logic [NL-1:0]   ext_req_tmask;
   logic [DW-1:0]   ext_req_data;
   logic [NE-1:0]   ext_rsp_valid;
   logic [NE*DW-1:0] ext_rsp_data;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [TW-1:0]   rsp_tag;
   logic [NW-1:0]   rsp_wid;
   logic [NL-1:0]   rsp_tmask;
   logic [DW-1:0]   rsp_data;

   int ntests = 0;
   int nfail  = 0;

   csr_ext_router #(
      .NUM_EXT(NE), .NUM_LANES(NL), .XLEN(XL), .NW_WIDTH(NW), .TAG_WIDTH(TW),
      .ADDR_BASE(BASE), .ADDR_END(ENDA), .DRAIN_MASK(4'b0100), .TIMEOUT(TO), .RSP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .req_wid(req_wid), .req_tmask(req_tmask), .req_data(req_data), .req_tag(req_tag),
      .drain_wid(drain_wid), .alm_empty(alm_empty),
      .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_write(ext_req_write),
      .ext_req_addr(ext_req_addr), .ext_req_wid(ext_req_wid), .ext_req_tmask(ext_req_tmask),
      .ext_req_data(ext_req_data), .ext_rsp_valid(ext_rsp_valid), .ext_rsp_data(ext_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_wid(rsp_wid),
      .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a request at a negedge; returns at the negedge of the cycle after acceptance
   task automatic do_req(input logic w, input logic [11:0] a, input logic [DW-1:0] d,
                         input logic [TW-1:0] t, input logic [NW-1:0] wid, input logic [NL-1:0] tm);
      int n;
      req_write = w; req_addr = a; req_data = d; req_tag = t; req_wid = wid; req_tmask = tm;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("accept_bound", n < 60, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pop();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   function automatic int exp_target(input logic [11:0] a);
      for (int i = 0; i < NE; i++)
         if (int'(a) >= base_a[i] && int'(a) < end_a[i]) return i;
      return -1;
   endfunction

   initial begin
      logic [63:0]   r64;
      logic [TW-1:0] tag_a, tag_b, tag_c;
      clk = 0; reset = 1;
      req_valid = 0; req_write = 0; req_addr = 0; req_wid = 0; req_tmask = 0; req_data = 0; req_tag = 0;
      alm_empty = 1; ext_req_ready = 0; ext_rsp_valid = 0; ext_rsp_data = 0; rsp_ready = 0;

      // reset values while reset is held
      @(negedge clk); @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_ext_valid", ext_req_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_drain_wid", drain_wid, 0);
      chk("rst_ext_addr", ext_req_addr, 0);
      reset = 0;
      @(negedge clk);
      chk("idle_req_ready", req_ready, 1);
      ext_req_ready = 4'hF;

      // mapped write to target 0
      do_req(1'b1, 12'h7C3, 128'h1234, 48'hA1, 4'h3, 4'hF);
      chk("wr_ext_valid", ext_req_valid, 4'b0001);
      chk("wr_ext_data", ext_req_data[31:0], 32'h1234);
      chk("wr_ext_write", ext_req_write, 1);
      chk("wr_rsp_early", rsp_valid, 0);
      @(negedge clk);
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_err", rsp_err, 0);
      chk("wr_rsp_data", rsp_data, 0);
      chk("wr_rsp_tag", rsp_tag, 48'hA1);
      pop();
      chk("wr_popped", rsp_valid, 0);

      // read from target 1, answer 5 cycles after issue
      do_req(1'b0, 12'h7CA, 128'h0, 48'hBEEF01, 4'h5, 4'b1010);
      chk("rd_ext_valid", ext_req_valid, 4'b0010);
      repeat (5) @(negedge clk);
      ext_rsp_valid = 4'b0010;
      ext_rsp_data[DW +: 32] = 32'hDEADBEEF;
      chk("rd_rsp_early", rsp_valid, 0);
      @(negedge clk);
      ext_rsp_valid = 0;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data[31:0], 32'hDEADBEEF);
      chk("rd_rsp_tag", rsp_tag, 48'hBEEF01);
      chk("rd_rsp_wid", rsp_wid, 4'h5);
      chk("rd_rsp_tmask", rsp_tmask, 4'b1010);
      chk("rd_rsp_err", rsp_err, 0);
      pop();

      // unmapped address
      do_req(1'b1, 12'h300, 128'h55, 48'hC3, 4'h1, 4'h1);
      chk("um_ext_valid", ext_req_valid, 0);
      chk("um_rsp_early", rsp_valid, 0);
      @(negedge clk);
      chk("um_rsp_valid", rsp_valid, 1);
      chk("um_rsp_err", rsp_err, 1);
      chk("um_rsp_data", rsp_data, 0);
      pop();

      // drain before issue to target 2
      alm_empty = 0;
      do_req(1'b1, 12'h7D2, 128'h77, 48'hD4, 4'h9, 4'hF);
      chk("dr_drain_wid", drain_wid, 4'h9);
      for (int i = 0; i < 10; i++) begin
         chk("dr_hold", ext_req_valid[2], 0);
         @(negedge clk);
      end
      alm_empty = 1;
      chk("dr_still_hold", ext_req_valid, 0);
      @(negedge clk);
      chk("dr_issue", ext_req_valid, 4'b0100);
      @(negedge clk);
      chk("dr_rsp_valid", rsp_valid, 1);
      pop();

      // read timeout on target 3, then a late response
      do_req(1'b0, 12'h7DA, 128'h0, 48'hE5, 4'h2, 4'hF);
      chk("to_ext_valid", ext_req_valid, 4'b1000);
      repeat (TO) @(negedge clk);
      chk("to_rsp_early", rsp_valid, 0);
      @(negedge clk);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_data", rsp_data, 0);
      repeat (3) @(negedge clk);
      ext_rsp_valid = 4'b1000;
      ext_rsp_data[3*DW +: 32] = 32'h0BAD;
      @(negedge clk);
      ext_rsp_valid = 0;
      chk("to_head_kept", rsp_err, 1);
      pop();
      chk("to_late_ignored", rsp_valid, 0);

      // FIFO full back-pressure
      tag_a = 48'hF1; tag_b = 48'hF2; tag_c = 48'hF3;
      do_req(1'b1, 12'h7C1, 128'h1, tag_a, 4'h0, 4'hF);
      do_req(1'b1, 12'h7D9, 128'h2, tag_b, 4'h0, 4'hF);
      @(negedge clk);
      req_write = 1; req_addr = 12'h7CC; req_data = 128'h3; req_tag = tag_c; req_valid = 1;
      chk("full_req_ready", req_ready, 0);
      repeat (3) @(negedge clk);
      chk("full_req_ready_hold", req_ready, 0);
      chk("full_no_issue", ext_req_valid, 0);
      chk("full_head_a", rsp_tag, tag_a);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("full_ready_after_pop", req_ready, 1);
      chk("full_head_b", rsp_tag, tag_b);
      @(negedge clk);
      req_valid = 0;
      chk("full_c_issue", ext_req_valid, 4'b0010);
      @(negedge clk);
      pop();
      chk("full_head_c", rsp_tag, tag_c);
      pop();
      chk("full_empty", rsp_valid, 0);

      // overlapping windows 0 and 1
      do_req(1'b1, 12'h7C6, 128'h9, 48'h66, 4'h0, 4'hF);
      chk("ovl_target0", ext_req_valid, 4'b0001);
      @(negedge clk);
      pop();

      // reset during WAIT_RSP
      do_req(1'b0, 12'h7C1, 128'h0, 48'h77, 4'h7, 4'hF);
      @(negedge clk); @(negedge clk);
      reset = 1;
      #1;
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_ext_valid", ext_req_valid, 0);
      chk("mr_req_ready", req_ready, 0);
      chk("mr_drain_wid", drain_wid, 0);
      chk("mr_ext_addr", ext_req_addr, 0);
      @(negedge clk);
      reset = 0;
      ext_rsp_valid = 4'b0001;
      @(negedge clk);
      ext_rsp_valid = 0;
      repeat (5) @(negedge clk);
      chk("mr_no_completion", rsp_valid, 0);
      chk("mr_ready_again", req_ready, 1);

      // randomized transactions against the reference model
      for (int k = 0; k < 40; k++) begin
         logic [11:0]   a;
         logic          w;
         logic [TW-1:0] t;
         logic [NW-1:0] wid;
         logic [NL-1:0] tm;
         logic [DW-1:0] d, rd;
         logic [NE-1:0] onehot;
         int            tgt, lat, cyc, hs;
         bit            seen;
         a   = ($urandom_range(0, 9) == 0) ? 12'h300 : 12'(32'h7B8 + $urandom_range(0, 47));
         w   = 1'($urandom_range(0, 1));
         r64 = {$urandom(), $urandom()};
         t   = r64[TW-1:0];
         wid = 4'($urandom_range(0, 15));
         tm  = 4'($urandom_range(0, 15));
         d   = {$urandom(), $urandom(), $urandom(), $urandom()};
         rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
         lat = $urandom_range(1, 12);
         tgt = exp_target(a);
         onehot = (tgt >= 0) ? 4'(1 << tgt) : 4'b0;
         do_req(w, a, d, t, wid, tm);
         cyc = 0; hs = -1; seen = 0;
         while (rsp_valid !== 1'b1 && cyc < 100) begin
            alm_empty     = 1'($urandom_range(0, 1));
            ext_req_ready = 4'($urandom_range(0, 15));
            ext_rsp_data  = {16{$urandom()}};
            ext_rsp_valid = 4'($urandom_range(0, 15)) & ~onehot;
            if (tgt >= 0 && hs >= 0 && cyc == hs + lat) begin
               ext_rsp_valid[tgt] = 1'b1;
               ext_rsp_data[tgt*DW +: DW] = rd;
            end
            if (ext_req_valid != 0 && !seen) begin
               seen = 1;
               chk("rnd_onehot", ext_req_valid, onehot);
               chk("rnd_ext_addr", ext_req_addr, a);
               chk("rnd_ext_data", ext_req_data, d);
            end
            if (ext_req_valid != 0 && hs < 0 && tgt >= 0 && ext_req_ready[tgt]) hs = cyc;
            @(negedge clk);
            cyc++;
         end
         ext_rsp_valid = 0;
         alm_empty = 1;
         chk("rnd_done", rsp_valid, 1);
         chk("rnd_tag", rsp_tag, t);
         chk("rnd_wid", rsp_wid, wid);
         chk("rnd_tmask", rsp_tmask, tm);
         if (tgt < 0 || (!w && lat > TO)) begin
            chk("rnd_err", rsp_err, 1);
            chk("rnd_data", rsp_data, 0);
         end else if (w) begin
            chk("rnd_err", rsp_err, 0);
            chk("rnd_data", rsp_data, 0);
         end else begin
            chk("rnd_err", rsp_err, 0);
            chk("rnd_data", rsp_data, rd);
         end
         pop();
         chk("rnd_single", rsp_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
